hazard_stall_ctrl: RTL and testbench

Pipeline hazard controller for the five-stage MIPS core. It decides when IF/ID must hold and when a bubble goes into ID/EX: load-use hazards, branches resolved in ID whose operands are not yet forwardable, and HI/LO hazards. It also sequences the multi-cycle multiply/divide unit through a small busy/done state machine. It sits beside the forwarding units and drives the PC, IF/ID and ID/EX register enables.

---
 rtl/hazard_pkg.sv | 24 ++
 rtl/hazard_stall_ctrl_md_seq.sv | 74 +++++++
 rtl/hazard_stall_ctrl.sv | 85 ++++++++
 tb/tb_hazard_stall_ctrl.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// Shared types and constants for the hazard/stall controller and its
// multiply/divide sequencer.
package hazard_pkg;

    // Multiply/divide sequencer state encoding
    typedef enum logic [1:0] {
        MD_IDLE = 2'd0,
        MD_BUSY = 2'd1,
        MD_DONE = 2'd2
    } md_state_e;

    // Default occupancy of the HI/LO unit, in cycles
    localparam int MUL_CYCLES_DEF = 4;
    localparam int DIV_CYCLES_DEF = 33;

    // Source/destination match: $zero never creates a dependency, and an
    // operand the instruction does not read never matches.
    function automatic logic reg_match(input logic [4:0] src,
                                       input logic       use_src,
                                       input logic [4:0] dst);
        return use_src && (src != 5'd0) && (src == dst);
    endfunction

endpackage

// File: rtl/hazard_stall_ctrl_md_seq.sv
// md_seq: busy/done sequencer for the multi-cycle HI/LO unit.
// start loads the down-counter with (N-1); the FSM leaves BUSY when the
// counter reaches zero, spends one cycle in DONE, then returns to IDLE.
module md_seq
    import hazard_pkg::*;
#(
    parameter int MUL_CYCLES = MUL_CYCLES_DEF,
    parameter int DIV_CYCLES = DIV_CYCLES_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic start,
    input  logic div,
    input  logic flush,
    output logic busy,
    output logic done,
    output logic sel_div
);

    localparam int MAXC = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
    localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;
    localparam logic [CW-1:0] MUL_LOAD = CW'(MUL_CYCLES - 1);
    localparam logic [CW-1:0] DIV_LOAD = CW'(DIV_CYCLES - 1);

    md_state_e       state, state_nx;
    logic [CW-1:0]   cnt, cnt_nx;
    logic            sel_nx;

    // State, counter and operation-select registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= MD_IDLE;
            cnt     <= '0;
            sel_div <= 1'b0;
        end else begin
            state   <= state_nx;
            cnt     <= cnt_nx;
            sel_div <= sel_nx;
        end
    end

    // Next-state logic; a flush abandons the operation and swallows md_done
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        sel_nx   = sel_div;
        done     = 1'b0;
        case (state)
            MD_IDLE: begin
                if (start) begin
                    state_nx = MD_BUSY;
                    cnt_nx   = div ? DIV_LOAD : MUL_LOAD;
                    sel_nx   = div;
                end
            end
            MD_BUSY: begin
                if (flush)
                    state_nx = MD_IDLE;
                else if (cnt == '0)
                    state_nx = MD_DONE;
                else
                    cnt_nx = cnt - 1'b1;
            end
            MD_DONE: begin
                done     = ~flush;
                state_nx = MD_IDLE;
            end
            default: state_nx = MD_IDLE;
        endcase
    end

    assign busy = (state != MD_IDLE);

endmodule

// File: rtl/hazard_stall_ctrl.sv
// hazard_stall_ctrl: combinational stall/bubble decision for the 5-stage
// core (load-use, branch-in-ID operand, HI/LO hazards) plus the HI/LO
// sequencer. Optional stall counter enabled by HAZARD_PERF_CNT_EN.
module hazard_stall_ctrl
    import hazard_pkg::*;
#(
    parameter int MUL_CYCLES = MUL_CYCLES_DEF,
    parameter int DIV_CYCLES = DIV_CYCLES_DEF
`ifdef HAZARD_PERF_CNT_EN
   ,parameter int CNT_W      = 32
`endif
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [4:0] id_rs,
    input  logic [4:0] id_rt,
    input  logic       id_use_rs,
    input  logic       id_use_rt,
    input  logic       id_is_branch,
    input  logic       id_is_mfhilo,
    input  logic       id_is_md,
    input  logic       id_md_div,
    input  logic       ex_reg_write,
    input  logic       ex_mem_read,
    input  logic [4:0] ex_rd,
    input  logic       mem_mem_read,
    input  logic [4:0] mem_rd,
    input  logic       flush,
    output logic       stall_pc,
    output logic       stall_if_id,
    output logic       bubble_id_ex,
    output logic       md_busy,
    output logic       md_done,
    output logic       md_sel_div
`ifdef HAZARD_PERF_CNT_EN
   ,output logic [CNT_W-1:0] stall_cnt
`endif
);

    logic ex_hit, mem_hit;
    logic load_use, br_ex, br_mem, md_hz;
    logic stall, stall_eff, md_start;

    // Hazard terms; the stall path is purely combinational
    always_comb begin
        ex_hit    = reg_match(id_rs, id_use_rs, ex_rd)  | reg_match(id_rt, id_use_rt, ex_rd);
        mem_hit   = reg_match(id_rs, id_use_rs, mem_rd) | reg_match(id_rt, id_use_rt, mem_rd);
        load_use  = ex_mem_read & ex_hit;
        br_ex     = id_is_branch & ex_reg_write & ex_hit;
        br_mem    = id_is_branch & mem_mem_read & mem_hit;
        md_hz     = (id_is_md | id_is_mfhilo) & md_busy;
        stall     = load_use | br_ex | br_mem | md_hz;
        stall_eff = stall & ~flush;
        md_start  = id_is_md & ~stall & ~flush;
    end

    assign stall_pc     = stall_eff;
    assign stall_if_id  = stall_eff;
    assign bubble_id_ex = stall_eff;

    md_seq #(
        .MUL_CYCLES (MUL_CYCLES),
        .DIV_CYCLES (DIV_CYCLES)
    ) u_md_seq (
        .clk     (clk),
        .reset   (reset),
        .start   (md_start),
        .div     (id_md_div),
        .flush   (flush),
        .busy    (md_busy),
        .done    (md_done),
        .sel_div (md_sel_div)
    );

`ifdef HAZARD_PERF_CNT_EN
    // Count every cycle the front end is actually held (wraps)
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            stall_cnt <= '0;
        else if (stall_eff)
            stall_cnt <= stall_cnt + 1'b1;
    end
`endif

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Directed self-checking bench for hazard_stall_ctrl (default cycle counts).
module tb_hazard_stall_ctrl;

    logic       clk, reset;
    logic [4:0] id_rs, id_rt, ex_rd, mem_rd;
    logic       id_use_rs, id_use_rt, id_is_branch, id_is_mfhilo, id_is_md, id_md_div;
    logic       ex_reg_write, ex_mem_read, mem_mem_read, flush;
    logic       stall_pc, stall_if_id, bubble_id_ex, md_busy, md_done, md_sel_div;
`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] stall_cnt;
`endif

    int checks = 0;
    int errors = 0;

    hazard_stall_ctrl dut (
        .clk          (clk),
        .reset        (reset),
        .id_rs        (id_rs),
        .id_rt        (id_rt),
        .id_use_rs    (id_use_rs),
        .id_use_rt    (id_use_rt),
        .id_is_branch (id_is_branch),
        .id_is_mfhilo (id_is_mfhilo),
        .id_is_md     (id_is_md),
        .id_md_div    (id_md_div),
        .ex_reg_write (ex_reg_write),
        .ex_mem_read  (ex_mem_read),
        .ex_rd        (ex_rd),
        .mem_mem_read (mem_mem_read),
        .mem_rd       (mem_rd),
        .flush        (flush),
        .stall_pc     (stall_pc),
        .stall_if_id  (stall_if_id),
        .bubble_id_ex (bubble_id_ex),
        .md_busy      (md_busy),
        .md_done      (md_done),
        .md_sel_div   (md_sel_div)
`ifdef HAZARD_PERF_CNT_EN
       ,.stall_cnt    (stall_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // All three stall outputs must agree with the expected stall value
    task automatic chk_stall(input string tag, input logic exp);
        chk(tag, {29'd0, stall_pc, stall_if_id, bubble_id_ex}, exp ? 32'd7 : 32'd0);
    endtask

    task automatic clr();
        id_rs = 0; id_rt = 0; ex_rd = 0; mem_rd = 0;
        id_use_rs = 0; id_use_rt = 0; id_is_branch = 0; id_is_mfhilo = 0;
        id_is_md = 0; id_md_div = 0; ex_reg_write = 0; ex_mem_read = 0;
        mem_mem_read = 0; flush = 0;
    endtask

    // Inputs change 1 time unit after a rising edge; checks follow 1 unit later
    task automatic tick();
        @(posedge clk); #1;
    endtask

    initial begin
        logic saw_done;
        reset = 1'b1;
        clr();
        #12;
        chk_stall("reset_stall", 1'b0);
        chk("reset_busy", {31'd0, md_busy}, 32'd0);
        chk("reset_done", {31'd0, md_done}, 32'd0);
        chk("reset_sel", {31'd0, md_sel_div}, 32'd0);
        reset = 1'b0;
        tick();

        // Load-use on rs, then the bubble sits in EX
        ex_mem_read = 1; ex_rd = 8; id_rs = 8; id_use_rs = 1; #1;
        chk_stall("load_use_rs", 1'b1);
        tick(); ex_mem_read = 0; #1;
        chk_stall("load_use_bubble", 1'b0);

        // $zero and unused-operand cases
        clr(); ex_mem_read = 1; ex_rd = 0; id_rs = 0; id_use_rs = 1; #1;
        chk_stall("load_r0", 1'b0);
        ex_rd = 8; id_rs = 3; id_rt = 8; id_use_rt = 0; #1;
        chk_stall("load_rt_unused", 1'b0);
        id_use_rt = 1; #1;
        chk_stall("load_rt_used", 1'b1);
        flush = 1; #1;
        chk_stall("load_flush_wins", 1'b0);

        // Branch operand hazards
        clr(); tick();
        id_is_branch = 1; id_rs = 9; id_use_rs = 1; ex_reg_write = 1; ex_rd = 9; #1;
        chk_stall("br_ex", 1'b1);
        tick(); ex_reg_write = 0; ex_rd = 0; mem_mem_read = 1; mem_rd = 9; #1;
        chk_stall("br_mem_load", 1'b1);
        tick(); mem_mem_read = 0; #1;
        chk_stall("br_mem_alu", 1'b0);
        ex_reg_write = 1; ex_rd = 9; id_is_branch = 0; #1;
        chk_stall("no_branch_ex_alu", 1'b0);

        // Divide: accepted at T, mfhi waits in ID until T+35
        clr(); tick();
        id_is_md = 1; id_md_div = 1; #1;
        chk_stall("div_accept", 1'b0);
        tick(); clr(); id_is_mfhilo = 1; #1;
        chk("div_sel", {31'd0, md_sel_div}, 32'd1);
        for (int k = 1; k <= 34; k++) begin
            chk("div_busy", {31'd0, md_busy}, 32'd1);
            chk("div_done", {31'd0, md_done}, (k == 34) ? 32'd1 : 32'd0);
            chk_stall("div_mfhi_stall", 1'b1);
            tick();
        end
        chk("div_idle", {31'd0, md_busy}, 32'd0);
        chk("div_done_gone", {31'd0, md_done}, 32'd0);
        chk_stall("div_mfhi_release", 1'b0);

        // Multiply back-to-back: second mult accepted in first IDLE cycle
        clr(); tick();
        id_is_md = 1; id_md_div = 0; #1;
        chk_stall("mul_accept", 1'b0);
        tick();
        chk("mul_sel", {31'd0, md_sel_div}, 32'd0);
        for (int k = 1; k <= 5; k++) begin
            chk("mul_busy", {31'd0, md_busy}, 32'd1);
            chk("mul_done", {31'd0, md_done}, (k == 5) ? 32'd1 : 32'd0);
            chk_stall("mul_b2b_stall", 1'b1);
            tick();
        end
        chk("mul_idle", {31'd0, md_busy}, 32'd0);
        chk_stall("mul_b2b_accept", 1'b0);
        tick(); id_is_md = 0; #1;
        chk("mul2_busy", {31'd0, md_busy}, 32'd1);
        flush = 1; #1;
        chk_stall("mul2_flush", 1'b0);
        tick(); flush = 0; #1;
        chk("mul2_flushed_idle", {31'd0, md_busy}, 32'd0);

        // Divide flushed at T+5: no md_done ever
        clr(); tick();
        id_is_md = 1; id_md_div = 1; #1;
        tick(); clr(); id_is_mfhilo = 1;
        for (int k = 1; k < 5; k++) tick();
        flush = 1; #1;
        chk_stall("divflush_stall", 1'b0);
        chk("divflush_done", {31'd0, md_done}, 32'd0);
        tick(); flush = 0; #1;
        chk("divflush_idle", {31'd0, md_busy}, 32'd0);
        chk_stall("divflush_mfhi_free", 1'b0);
        clr();
        saw_done = 1'b0;
        for (int k = 0; k < 35; k++) begin
            if (md_done) saw_done = 1'b1;
            tick();
        end
        chk("divflush_never_done", {31'd0, saw_done}, 32'd0);

        // Flush during DONE swallows the pulse
        id_is_md = 1; id_md_div = 0; #1;
        tick(); clr();
        for (int k = 1; k < 5; k++) tick();
        chk("mulflush_in_busy", {31'd0, md_busy}, 32'd1);
        flush = 1; #1;
        chk("mulflush_done_sup", {31'd0, md_done}, 32'd0);
        tick(); flush = 0; #1;
        chk("mulflush_idle", {31'd0, md_busy}, 32'd0);

        // Asynchronous reset mid-divide
        id_is_md = 1; id_md_div = 1; #1;
        tick(); clr(); tick(); tick();
        #2 reset = 1'b1; #1;
        chk("areset_busy", {31'd0, md_busy}, 32'd0);
        chk("areset_done", {31'd0, md_done}, 32'd0);
        chk("areset_sel", {31'd0, md_sel_div}, 32'd0);
        #1 reset = 1'b0;
        tick();

`ifdef HAZARD_PERF_CNT_EN
        // Stall counter: three held cycles, then cleared by reset
        reset = 1'b1; #1;
        chk("cnt_reset", stall_cnt, 32'd0);
        reset = 1'b0; tick();
        ex_mem_read = 1; ex_rd = 4; id_rs = 4; id_use_rs = 1;
        tick(); tick(); tick();
        clr(); #1;
        chk("cnt_three", stall_cnt, 32'd3);
        tick(); #2 reset = 1'b1; #1;
        chk("cnt_midrun_reset", stall_cnt, 32'd0);
        reset = 1'b0;
        tick();
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
